// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder behind the CPU dmem port.
// Accepts one byte-masked read/write request and answers with a one-cycle dmem_resp
// LATENCY cycles later. The word is served from an internal word-addressed array.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   dmem_addr     - byte address of the request (bits [1:0] ignored)
//   dmem_rmask    - read byte mask, nonzero = read request
//   dmem_wmask    - write byte mask, nonzero = write request
//   dmem_wdata    - write data, byte lanes per dmem_wmask
//   dmem_rdata    - full 32-bit word, valid while dmem_resp=1, held otherwise
//   dmem_resp     - one-cycle response strobe
//   o_busy        - request in flight (cycle after acceptance through RESP)
//   o_err         - sticky: out-of-range access or request presented while busy
//   o_err_clr     - synchronous clear of o_err (a simultaneous set wins)
// Optional build macro DMEM_RAND_LATENCY_EN: a 16-bit Galois LFSR adds 0..3
// extra WAIT cycles per request, sampled at acceptance.

module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        o_busy,
  output logic        o_err,
  input  logic        o_err_clr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Counter must hold LATENCY-1 plus up to 3 random extra cycles.
  localparam int unsigned CNT_W = $clog2(LATENCY + 4);
  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               in_range_q, in_range_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic               req;
  logic [31:0]        offset;
  logic               req_in_range;
  logic [IDX_W-1:0]   req_idx;
  logic               unused_addr_lsbs;

  assign req    = (|dmem_rmask) | (|dmem_wmask);
  assign offset = dmem_addr - BASE_ADDR;
  // Below BASE the subtraction wraps, so the lower bound is checked separately;
  // the upper bound is "no offset bits above the array span".
  assign req_in_range = (dmem_addr >= BASE_ADDR) && (offset[31:IDX_W+2] == '0);
  assign req_idx      = offset[IDX_W+1:2];
  assign unused_addr_lsbs = ^offset[1:0];

  // ---------------------------------------------------------------------------
  // Counter load value (fixed, or fixed plus LFSR-selected extra wait)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] load_cnt;

`ifdef DMEM_RAND_LATENCY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign load_cnt = CNT_BASE + CNT_W'(lfsr_q[1:0]);
`else
  assign load_cnt = CNT_BASE;
`endif

  // ---------------------------------------------------------------------------
  // Response word. When LATENCY==1 the FSM jumps IDLE->RESP, so the word for
  // the RESP cycle must be formed from the live request; otherwise from the
  // latched copy. The merged word covers combined read+write requests, which
  // must observe their own write.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] src_idx;
  logic [3:0]       src_wmask;
  logic [31:0]      src_wdata;
  logic             src_in_range;
  logic [31:0]      mem_word;
  logic [31:0]      merged_word;

  always_comb begin
    if (state_q == ST_IDLE) begin
      src_idx      = req_idx;
      src_wmask    = dmem_wmask;
      src_wdata    = dmem_wdata;
      src_in_range = req_in_range;
    end else begin
      src_idx      = idx_q;
      src_wmask    = wmask_q;
      src_wdata    = wdata_q;
      src_in_range = in_range_q;
    end
    mem_word    = mem[src_idx];
    merged_word = mem_word;
    for (int b = 0; b < 4; b++) begin
      if (src_wmask[b]) begin
        merged_word[8*b +: 8] = src_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and request latch
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d      = req_idx;
          in_range_d = req_in_range;
          wmask_d    = dmem_wmask;
          wdata_d    = dmem_wdata;
          cnt_d      = load_cnt;
          state_d    = (load_cnt == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read data and error flag
  // ---------------------------------------------------------------------------
  logic set_busy_err;
  logic set_range_err;

  // A request seen while not idle is dropped; flag it.
  assign set_busy_err  = req && (state_q != ST_IDLE);
  // Range error becomes visible together with the response.
  assign set_range_err = (state_d == ST_RESP) && (state_q != ST_RESP) && !src_in_range;

  always_comb begin
    rdata_d = rdata_q;
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      rdata_d = src_in_range ? merged_word : 32'h0;
    end
    err_d = (err_q & ~o_err_clr) | set_busy_err | set_range_err;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Array write: committed at the edge that ends RESP. Reset forces IDLE
  // asynchronously, so an interrupted write never lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_RESP) && in_range_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign dmem_resp  = (state_q == ST_RESP);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_err      = err_q;
  assign dmem_rdata = rdata_q;

endmodule
